mlsu_seq_store_wbuf: RTL and testbench

Write-data buffer and AXI W/B sequencer for the MLSU sequential-store path. It accepts one store transaction command at a time and packs bus-wide data chunks read from the MRF into a `WBufDep`-deep FIFO. It emits AXI W beats with the correct strobes and `wlast`, then waits for the matching B response and reports completion with an error flag. It sits between the MRF read/shuffle stage and the AXI master port of the MLSU.

---
 rtl/mlsu_seq_store_wbuf.sv | 145 ++++++++++++++
 tb/tb_mlsu_seq_store_wbuf.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mlsu_seq_store_wbuf.sv
// Sequential-store write buffer: packs MRF beats into a small FIFO, drives AXI W
// with first/middle/last strobes, then waits for the B response and reports completion.
module mlsu_seq_store_wbuf #(
  parameter int BusBits = 512,
  parameter int IdBits  = 1,
  parameter int WBufDep = 2,
  localparam int BusBytes = BusBits / 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [7:0]          cmd_len_i,
  input  logic [IdBits-1:0]   cmd_id_i,
  input  logic [BusBytes-1:0] cmd_strb_first_i,
  input  logic [BusBytes-1:0] cmd_strb_last_i,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  input  logic [BusBits-1:0]  data_i,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  output logic [BusBits-1:0]  w_data_o,
  output logic [BusBytes-1:0] w_strb_o,
  output logic                w_last_o,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [IdBits-1:0]   b_id_i,
  input  logic [1:0]          b_resp_i,
  output logic                done_valid_o,
  output logic                done_err_o,
  output logic                busy_o
);
  localparam int PtrW = $clog2(WBufDep);
  localparam int CntW = $clog2(WBufDep + 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_B} state_e;
  state_e state, state_nxt;

  logic [7:0]          len;
  logic [IdBits-1:0]   id;
  logic [BusBytes-1:0] strb_first, strb_last;
  logic [8:0]          in_cnt, out_cnt;

  logic [BusBits-1:0]  mem_data [WBufDep];
  logic [BusBytes-1:0] mem_strb [WBufDep];
  logic [WBufDep-1:0]  mem_last;
  logic [PtrW-1:0]     wr_ptr, rd_ptr;
  logic [CntW-1:0]     fifo_cnt;

  logic                cmd_fire, push, pop, b_fire;
  logic [BusBytes-1:0] enq_strb;
  logic                enq_last;
  logic                done_valid, done_err;

  assign cmd_ready_o  = (state == IDLE);
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;
  // Uses only registered state so there is no path from w_ready_i
  assign data_ready_o = (state == STREAM) && (fifo_cnt < CntW'(WBufDep)) && (in_cnt <= {1'b0, len});
  assign push         = data_valid_i && data_ready_o;
  assign w_valid_o    = (fifo_cnt != '0);
  assign pop          = w_valid_o && w_ready_i;
  assign w_data_o     = w_valid_o ? mem_data[rd_ptr] : '0;
  assign w_strb_o     = w_valid_o ? mem_strb[rd_ptr] : '0;
  assign w_last_o     = w_valid_o && mem_last[rd_ptr];
  assign b_ready_o    = (state == WAIT_B);
  assign b_fire       = b_valid_i && b_ready_o;
  assign busy_o       = (state != IDLE);
  assign done_valid_o = done_valid;
  assign done_err_o   = done_err;

  always_comb begin
    enq_strb = '1;
    enq_last = 1'b0;
    if (in_cnt == 9'd0 && len == 8'd0) begin
      enq_strb = strb_first & strb_last;
      enq_last = 1'b1;
    end else if (in_cnt == 9'd0) begin
      enq_strb = strb_first;
    end else if (in_cnt == {1'b0, len}) begin
      enq_strb = strb_last;
      enq_last = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = STREAM;
      STREAM:  if (pop && w_last_o && (out_cnt == {1'b0, len})) state_nxt = WAIT_B;
      WAIT_B:  if (b_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      len        <= '0;
      id         <= '0;
      strb_first <= '0;
      strb_last  <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      mem_last   <= '0;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_valid <= b_fire;
      done_err   <= b_fire && ((b_resp_i != 2'b00) || (b_id_i != id));
      if (cmd_fire) begin
        len        <= cmd_len_i;
        id         <= cmd_id_i;
        strb_first <= cmd_strb_first_i;
        strb_last  <= cmd_strb_last_i;
        in_cnt     <= '0;
        out_cnt    <= '0;
      end else begin
        if (push) in_cnt  <= in_cnt + 9'd1;
        if (pop)  out_cnt <= out_cnt + 9'd1;
      end
      if (push) begin
        mem_last[wr_ptr] <= enq_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Payload storage needs no reset: the pointers and count define validity
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= data_i;
      mem_strb[wr_ptr] <= enq_strb;
    end
  end
endmodule

// File: tb/tb_mlsu_seq_store_wbuf.sv
// Scoreboard bench for mlsu_seq_store_wbuf: expected W beats and done flags are
// queued as stimulus is accepted and checked as the DUT emits them.
module tb_mlsu_seq_store_wbuf;
  localparam int BusBits = 512, BusBytes = 64, IdBits = 1, WBufDep = 2;
  localparam logic [BusBytes-1:0] SF = 64'hFFFF_FFFF_FFFF_FF00;
  localparam logic [BusBytes-1:0] SL = 64'h0FFF_FFFF_FFFF_FFFF;
  localparam logic [BusBytes-1:0] SF2 = 64'hF0F0_0000_FFFF_0000;
  localparam logic [BusBytes-1:0] SL2 = 64'h0000_0000_0000_00FF;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                cmd_valid, cmd_ready, data_valid, data_ready;
  logic [7:0]          cmd_len;
  logic [IdBits-1:0]   cmd_id, b_id;
  logic [BusBytes-1:0] cmd_sf, cmd_sl, w_strb;
  logic [BusBits-1:0]  data_i, w_data;
  logic                w_valid, w_ready, w_last, b_valid, b_ready;
  logic [1:0]          b_resp;
  logic                done_valid, done_err, busy;

  mlsu_seq_store_wbuf #(.BusBits(BusBits), .IdBits(IdBits), .WBufDep(WBufDep)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len), .cmd_id_i(cmd_id),
    .cmd_strb_first_i(cmd_sf), .cmd_strb_last_i(cmd_sl),
    .data_valid_i(data_valid), .data_ready_o(data_ready), .data_i(data_i),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_id_i(b_id), .b_resp_i(b_resp),
    .done_valid_o(done_valid), .done_err_o(done_err), .busy_o(busy)
  );

  typedef struct { logic [BusBits-1:0] d; logic [BusBytes-1:0] s; logic l; } beat_t;
  beat_t wq[$];
  logic  dq[$];
  beat_t exp_b, hold;
  int    tests = 0, fails = 0;
  int    n_in = 0, n_out = 0, done_cnt = 0, cyc = 0, w_first = 0, w_last_c = 0;
  bit    d_fire, c_fire, b_fire, w_pend;
  logic [7:0]          m_len;
  logic [BusBytes-1:0] m_sf, m_sl;

  task automatic chk(input string tag, input logic [BusBits-1:0] got, input logic [BusBits-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BusBits-1:0] rnd();
    logic [BusBits-1:0] r;
    for (int i = 0; i < BusBits / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: handshakes seen at the negedge complete on the following posedge
  always @(negedge clk) begin
    cyc++;
    d_fire = 1'b0; c_fire = 1'b0; b_fire = 1'b0;
    if (!rst_n) begin
      wq.delete(); dq.delete(); w_pend = 1'b0; n_in = 0; n_out = 0;
    end else begin
      if (w_pend) begin
        chk("w_hold_v", w_valid, 1);
        chk("w_hold_d", w_data, hold.d);
        chk("w_hold_s", w_strb, hold.s);
        chk("w_hold_l", w_last, hold.l);
      end
      w_pend = w_valid && !w_ready;
      hold   = '{w_data, w_strb, w_last};
      if (cmd_valid && cmd_ready) begin
        c_fire = 1'b1; m_len = cmd_len; m_sf = cmd_sf; m_sl = cmd_sl; n_in = 0; n_out = 0;
      end
      if (data_valid && data_ready) begin
        exp_b.d = data_i; exp_b.l = 1'b0; exp_b.s = '1;
        if (n_in == 0 && m_len == 0) begin exp_b.s = m_sf & m_sl; exp_b.l = 1'b1; end
        else if (n_in == 0) exp_b.s = m_sf;
        else if (n_in == m_len) begin exp_b.s = m_sl; exp_b.l = 1'b1; end
        wq.push_back(exp_b);
        n_in++; d_fire = 1'b1;
      end
      if (w_valid && w_ready) begin
        chk("w_q", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          exp_b = wq.pop_front();
          chk("w_data", w_data, exp_b.d);
          chk("w_strb", w_strb, exp_b.s);
          chk("w_last", w_last, exp_b.l);
        end
        if (n_out == 0) w_first = cyc;
        w_last_c = cyc;
        n_out++;
      end
      if (b_valid && b_ready) b_fire = 1'b1;
      if (done_valid) begin
        done_cnt++;
        chk("done_q", dq.size() != 0, 1);
        if (dq.size() != 0) chk("done_err", done_err, dq.pop_front());
      end
    end
  end

  task automatic txn(input int len, input logic [IdBits-1:0] id, input logic [IdBits-1:0] bid,
                     input logic [1:0] resp, input logic [BusBytes-1:0] sf, input logic [BusBytes-1:0] sl,
                     input int wstall, input bit wrand, input bit hold_dv, input int rst_at);
    int k, dbase;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_len = len[7:0]; cmd_id = id; cmd_sf = sf; cmd_sl = sl;
    @(posedge clk); #1;
    chk("cmd_hs", c_fire, 1);
    chk("w_early", w_valid, 0);
    cmd_valid = 1'b0; data_valid = 1'b1; data_i = rnd();
    k = 0;
    while (n_out < len + 1) begin
      w_ready = (k < wstall) ? 1'b0 : (wrand ? ($urandom_range(0, 3) != 0) : 1'b1);
      @(posedge clk); #1;
      k++;
      if (d_fire) begin
        if (n_in == len + 1 && !hold_dv) data_valid = 1'b0;
        else data_i = rnd();
      end
      if (wstall >= 10 && k == 8) begin
        chk("bp_in", n_in, 2);
        chk("bp_drdy", data_ready, 0);
      end
      if (rst_at >= 0 && n_out == rst_at) begin
        rst_n = 1'b0; #1;
        chk("rst_wv", w_valid, 0);
        chk("rst_crdy", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_drdy", data_ready, 0);
        data_valid = 1'b0; w_ready = 1'b0;
        dbase = done_cnt;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1; chk("rst_nodone", done_cnt, dbase);
        return;
      end
      if (k > 4000) begin
        chk("timeout", 1, 0);
        break;
      end
    end
    if (hold_dv) chk("no_extra", n_in, len + 1);
    if (!wrand && wstall == 0) chk("w_consec", w_last_c - w_first, len);
    chk("b_rdy", b_ready, 1);
    data_valid = 1'b0; w_ready = 1'b0;
    dbase = done_cnt;
    b_valid = 1'b1; b_id = bid; b_resp = resp;
    dq.push_back((resp != 2'b00) || (bid != id));
    @(posedge clk); #1;
    chk("b_hs", b_fire, 1);
    b_valid = 1'b0;
    chk("done_v", done_valid, 1);
    chk("busy_idle", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse", done_valid, 0);
    chk("done_cnt", done_cnt, dbase + 1);
  endtask

  initial begin
    cmd_valid = 0; cmd_len = 0; cmd_id = 0; cmd_sf = 0; cmd_sl = 0;
    data_valid = 0; data_i = '0; w_ready = 0; b_valid = 0; b_id = 0; b_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_strb", w_strb, 0);
    chk("rst_w_last", w_last, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_busy0", busy, 0);
    rst_n = 1'b1;
    txn(0,   1'b0, 1'b0, 2'b00, SF,  SL,  0,  1'b0, 1'b0, -1);
    txn(7,   1'b1, 1'b1, 2'b00, SF,  SL,  0,  1'b0, 1'b1, -1);
    txn(3,   1'b0, 1'b0, 2'b00, SF2, SL2, 10, 1'b0, 1'b0, -1);
    txn(2,   1'b0, 1'b0, 2'b10, SF2, SL,  0,  1'b1, 1'b0, -1);
    txn(1,   1'b1, 1'b0, 2'b00, SF,  SL2, 0,  1'b0, 1'b0, -1);
    txn(255, 1'b1, 1'b1, 2'b00, SF,  SL,  0,  1'b1, 1'b0, -1);
    txn(7,   1'b0, 1'b0, 2'b00, SF2, SL2, 0,  1'b0, 1'b0, 3);
    txn(4,   1'b1, 1'b1, 2'b00, SF,  SL2, 0,  1'b1, 1'b0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
